seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display. It holds a 32-bit value (eight hex nibbles), steps the 3-bit digit select through 0..7 with a programmable on-time and anti-ghosting dead time, and drives active-low anodes, cathodes and decimal point. New values are double-buffered and applied only at frame boundaries, so the display never shows a mix of old and new digits. It sits between the debug/register-readout path of the pipeline and the FPGA display pins.

## Interface
- DIGIT_CYCLES, 100000: clocks each digit is lit; must be ≥1.
- BLANK_CYCLES, 1000: dead-time clocks before each digit, all anodes off; 0 removes the blank phase.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low forces IDLE (display dark).
- load  in  1  one-cycle strobe; captures data/dp_in/blank_in into the pending buffer.
- data  in  32  digit i value = data[4i+3:4i].
- dp_in  in  8  bit i lights the decimal point of digit i.
- blank_in  in  8  bit i keeps digit i dark during its slot.
- sel  out  3  current digit index.
- an  out  8  active-low anodes; ON phase: bit sel low, others high; else 8'hFF.
- seg  out  7  active-low cathodes {g,f,e,d,c,b,a}; 7'h7F when dark.
- dp  out  1  active-low decimal point; 1 when dark.
- frame_done  out  1  one-cycle pulse on the last ON cycle of digit 7.

## Operation
- FSM states: IDLE, BLANK, ON. One down-counter shared by BLANK and ON, width sized for max(DIGIT_CYCLES, BLANK_CYCLES).
- IDLE: sel=0, an=8'hFF, seg=7'h7F, dp=1. en=1 → BLANK (or ON if BLANK_CYCLES=0), counter loaded.
- BLANK: lasts exactly BLANK_CYCLES cycles, an=8'hFF; then → ON.
- ON: lasts exactly DIGIT_CYCLES cycles; an drives the one-cold pattern for sel, seg = hex glyph of nibble sel, dp = ~dp_bit[sel]. If blank bit[sel] set: an=8'hFF, seg=7'h7F, dp=1, slot timing unchanged. On expiry: sel ← sel+1 (7 wraps to 0) → BLANK (ON if BLANK_CYCLES=0).
- en low in any state: next cycle IDLE, sel=0, counter cleared. Re-enable always starts from digit 0.
- Glyphs (hex of seg): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- Buffering: load copies inputs into pending regs and sets pending_valid (later loads overwrite). Pending → display regs, pending_valid cleared, at the frame boundary (ON expiry of digit 7) or on any cycle in IDLE. load coincident with the boundary: the newly loaded values go directly to the display regs.
- Frame period = 8 × (BLANK_CYCLES + DIGIT_CYCLES) clocks.

## Timing
- Outputs are Moore: registered, functions of state/sel/display regs only; no combinational path from any input to any output.
- en sampled high at edge k in IDLE → first BLANK cycle after edge k; first ON cycle after edge k+BLANK_CYCLES.
- an is low for exactly DIGIT_CYCLES consecutive cycles per slot; never two anodes low at once; with BLANK_CYCLES≥1 at least BLANK_CYCLES all-high cycles between slots.
- frame_done high for exactly one cycle per frame, coinciding with the last ON cycle of digit 7; never high in IDLE.
- Reset (async assert, any state): state=IDLE, sel=0, an=8'hFF, seg=7'h7F, dp=1, frame_done=0, counter=0, display and pending regs=0, pending_valid=0. After reset with en=1 and no load, display shows "00000000", no dp.

## Test plan
Benches use DIGIT_CYCLES=4, BLANK_CYCLES=2.
- Reset then en=1, load data=32'h76543210 → digit0 slot: an=8'hFE, seg=7'h40 for 4 cycles after 2 dark cycles; digit7: an=8'h7F, seg=7'h78; frame period 48 cycles; frame_done once per 48.
- Mid-frame load of 32'hFFFFFFFF while showing digit 3 → digits 3..7 keep old glyphs; new glyph 7'h0E first appears at digit 0 of next frame.
- dp_in=8'h01, blank_in=8'h80 → digit0 dp=0 during ON; digit7 slot keeps an=8'hFF for all 6 cycles; timing and frame_done unchanged.
- Drop en during digit 5 ON → next cycle an=8'hFF, sel=0; re-raise → scan restarts at digit 0 after 2 blank cycles.
- Assert rst mid-ON of digit 2 → outputs reach reset values without a clock edge; display regs 0.
- BLANK_CYCLES=0 instance → digits back-to-back, an changes directly 8'hFE→8'hFD, frame period 32.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan controller for an 8-digit common-anode display
// double-buffered 32-bit hex value, programmable on-time and dead time
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] data,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  output logic [2:0]  sel,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int MAXC =
    (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] DLD = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLD =
    (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state;
  state_t        nstate;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ncnt;
  logic [2:0]    nsel;

  logic [31:0] disp_data;
  logic [7:0]  disp_dp;
  logic [7:0]  disp_bl;
  logic [31:0] pend_data;
  logic [7:0]  pend_dp;
  logic [7:0]  pend_bl;
  logic        pend_valid;

  logic [31:0] nd_data;
  logic [7:0]  nd_dp;
  logic [7:0]  nd_bl;

  logic        boundary;
  logic        apply;
  logic        lit;
  logic [3:0]  nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

  // next state, digit index and shared slot counter
  always_comb begin
    nstate = state;
    nsel   = sel;
    ncnt   = cnt;
    if (!en) begin
      nstate = IDLE;
      nsel   = 3'd0;
      ncnt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          nsel = 3'd0;
          if (BLANK_CYCLES > 0) begin
            nstate = BLANK;
            ncnt   = BLD;
          end else begin
            nstate = ON;
            ncnt   = DLD;
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            nstate = ON;
            ncnt   = DLD;
          end else begin
            ncnt = cnt - 1'b1;
          end
        end
        ON: begin
          if (cnt == '0) begin
            nsel = sel + 3'd1;
            if (BLANK_CYCLES > 0) begin
              nstate = BLANK;
              ncnt   = BLD;
            end else begin
              nstate = ON;
              ncnt   = DLD;
            end
          end else begin
            ncnt = cnt - 1'b1;
          end
        end
        default: begin
          nstate = IDLE;
          nsel   = 3'd0;
          ncnt   = '0;
        end
      endcase
    end
  end

  // the display copy only changes at a frame edge or while dark
  assign boundary = (state == ON) && (sel == 3'd7) && (cnt == '0);
  assign apply    = boundary || (state == IDLE);

  // display contents seen after the coming edge
  always_comb begin
    nd_data = disp_data;
    nd_dp   = disp_dp;
    nd_bl   = disp_bl;
    if (apply) begin
      if (load) begin
        nd_data = data;
        nd_dp   = dp_in;
        nd_bl   = blank_in;
      end else if (pend_valid) begin
        nd_data = pend_data;
        nd_dp   = pend_dp;
        nd_bl   = pend_bl;
      end
    end
  end

  assign lit = (nstate == ON) && !nd_bl[nsel];
  assign nib = nd_data[{nsel, 2'b00} +: 4];

  // pending and display buffers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_bl    <= '0;
      pend_valid <= 1'b0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_bl    <= '0;
    end else begin
      if (load) begin
        pend_data <= data;
        pend_dp   <= dp_in;
        pend_bl   <= blank_in;
      end
      if (apply)
        pend_valid <= 1'b0;
      else if (load)
        pend_valid <= 1'b1;
      disp_data <= nd_data;
      disp_dp   <= nd_dp;
      disp_bl   <= nd_bl;
    end
  end

  // scan FSM with registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 3'd0;
      cnt        <= '0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= nstate;
      sel        <= nsel;
      cnt        <= ncnt;
      an         <= lit ? ~(8'h01 << nsel) : 8'hFF;
      seg        <= lit ? glyph(nib) : 7'h7F;
      dp         <= lit ? ~nd_dp[nsel] : 1'b1;
      frame_done <= (nstate == ON) && (nsel == 3'd7) &&
                    (ncnt == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl
// two instances (blank 2 and blank 0), time-based reference model
module tb_seg_scan_ctrl;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;

  logic [2:0] sel0, sel1;
  logic [7:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, fd0, fd1;

  int ncmp = 0;
  int nbad = 0;
  int cyc = 0;

  // {sel, an, seg, dp, frame_done}
  typedef logic [19:0] exp_t;
  localparam exp_t RST_EXP = {3'd0, 8'hFF, 7'h7F, 1'b1, 1'b0};

  exp_t q0[$];
  exp_t q1[$];

  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                          7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03,
                          7'h46, 7'h21, 7'h06, 7'h0E};

  bit          run [2];
  int          t   [2];
  logic [31:0] dd  [2];
  logic [7:0]  ddp [2];
  logic [7:0]  dbl [2];
  logic [31:0] pd  [2];
  logic [7:0]  pdp [2];
  logic [7:0]  pbl [2];
  bit          pv  [2];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .data(data), .dp_in(dp_in), .blank_in(blank_in),
    .sel(sel0), .an(an0), .seg(seg0), .dp(dp0),
    .frame_done(fd0)
  );

  seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .data(data), .dp_in(dp_in), .blank_in(blank_in),
    .sel(sel1), .an(an1), .seg(seg1), .dp(dp1),
    .frame_done(fd1)
  );

  function automatic int bc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int slot_of(int i);
    return (t[i] / (bc(i) + DC)) % 8;
  endfunction

  function automatic int ph_of(int i);
    return t[i] % (bc(i) + DC);
  endfunction

  function automatic exp_t model_out(int i);
    int s, ph, p;
    bit lit;
    logic [7:0] ea;
    logic [6:0] es;
    logic [2:0] s3;
    logic ed, ef;
    if (!run[i]) return RST_EXP;
    p   = bc(i) + DC;
    s   = slot_of(i);
    ph  = ph_of(i);
    lit = (ph >= bc(i)) && !dbl[i][s];
    ea  = lit ? ~(8'h01 << s) : 8'hFF;
    es  = lit ? gl[dd[i][s*4 +: 4]] : 7'h7F;
    ed  = lit ? ~ddp[i][s] : 1'b1;
    ef  = (s == 7) && (ph == p - 1);
    s3  = s[2:0];
    return {s3, ea, es, ed, ef};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; t[i] = 0; pv[i] = 0;
      dd[i] = '0; ddp[i] = '0; dbl[i] = '0;
      pd[i] = '0; pdp[i] = '0; pbl[i] = '0;
    end
  endtask

  task automatic model_step(int i);
    int p;
    bit apply;
    p = bc(i) + DC;
    apply = !run[i] ||
            (slot_of(i) == 7 && ph_of(i) == p - 1);
    if (apply) begin
      if (load) begin
        dd[i] = data; ddp[i] = dp_in; dbl[i] = blank_in;
      end else if (pv[i]) begin
        dd[i] = pd[i]; ddp[i] = pdp[i]; dbl[i] = pbl[i];
      end
      pv[i] = 0;
    end else if (load) begin
      pd[i] = data; pdp[i] = dp_in; pbl[i] = blank_in;
      pv[i] = 1;
    end
    if (!en) begin
      run[i] = 0; t[i] = 0;
    end else if (!run[i]) begin
      run[i] = 1; t[i] = 0;
    end else begin
      t[i] = (t[i] + 1) % (8 * p);
    end
  endtask

  task automatic tick();
    model_step(0);
    q0.push_back(model_out(0));
    model_step(1);
    q1.push_back(model_out(1));
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic chk(string nm, exp_t got, exp_t want);
    ncmp++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s cyc=%0d got sel=%0d an=%h seg=%h dp=%b fd=%b want sel=%0d an=%h seg=%h dp=%b fd=%b",
               nm, cyc, got[19:17], got[16:9], got[8:2], got[1], got[0],
               want[19:17], want[16:9], want[8:2], want[1], want[0]);
    end
  endtask

  task automatic check_rst(string nm);
    chk({nm, "_u0"}, {sel0, an0, seg0, dp0, fd0}, RST_EXP);
    chk({nm, "_u1"}, {sel1, an1, seg1, dp1, fd1}, RST_EXP);
  endtask

  task automatic wait_lit(int s);
    bit hit = 0;
    for (int k = 0; k < 100; k++) begin
      if (run[0] && slot_of(0) == s && ph_of(0) >= bc(0)) begin
        hit = 1;
        break;
      end
      tick();
    end
    if (!hit) begin
      ncmp++;
      nbad++;
      $display("FAIL wait_digit%0d timed out got none want lit", s);
    end
  endtask

  // monitor: compare every presented output cycle against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (q0.size() > 0) chk("u0", {sel0, an0, seg0, dp0, fd0}, q0.pop_front());
    if (q1.size() > 0) chk("u1", {sel1, an1, seg1, dp1, fd1}, q1.pop_front());
  end

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1 check_rst("rst_async_start");
    @(posedge clk);
    #2 check_rst("rst_held");
    @(posedge clk);
    #6 rst = 1'b0;

    en = 1'b1;
    load = 1'b1;
    data = 32'h76543210;
    tick();
    repeat (60) tick();

    wait_lit(3);
    load = 1'b1;
    data = 32'hFFFFFFFF;
    tick();
    repeat (60) tick();

    load = 1'b1;
    data = 32'h9E1C3A5B;
    dp_in = 8'h01;
    blank_in = 8'h80;
    tick();
    repeat (70) tick();

    wait_lit(5);
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    repeat (20) tick();

    wait_lit(2);
    #2 rst = 1'b1;
    #1 check_rst("rst_mid_on");
    q0.delete();
    q1.delete();
    model_reset();
    #2 rst = 1'b0;
    dp_in = 8'h00;
    blank_in = 8'h00;
    repeat (50) tick();

    repeat (500) begin
      en = ($urandom % 60) != 0;
      load = ($urandom % 10) == 0;
      data = $urandom;
      dp_in = 8'($urandom);
      blank_in = 8'($urandom & $urandom & $urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
